// File: rtl/countdown_timer_ctrl.sv
// Programmable countdown timer: prescaled down-counter with load/start, pause,
// abort, optional auto-reload and a one-cycle completion pulse on done.
module countdown_timer_ctrl #(
    parameter int WIDTH       = 4,
    parameter int PRESCALE    = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // tick depends on the live pause/abort inputs so it never claims a
    // decrement that a same-cycle pause or abort will suppress.
    assign tick = (state_q == RUN) && (presc_q == PRESC_MAX) && !pause && !abort;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    count_d  = load_val;
                    reload_d = load_val;
                    presc_d  = '0;
                    state_d  = (load_val != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    count_d = '0;
                    presc_d = '0;
                    state_d = IDLE;
                end else if (pause) begin
                    state_d = PAUSED;
                end else if (tick) begin
                    presc_d = '0;
                    // Treat 0 like 1 so a corrupted count can never wrap to all-ones.
                    if (count_q <= WIDTH'(1)) begin
                        count_d = '0;
                        state_d = DONE;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            PAUSED: begin
                if (abort) begin
                    count_d = '0;
                    presc_d = '0;
                    state_d = IDLE;
                end else if (!pause) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (!abort && AUTO_RELOAD && (reload_q != '0)) begin
                    count_d = reload_q;
                    presc_d = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN) || (state_d == PAUSED);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            presc_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl: one instance with PRESCALE=2 and one
// auto-reloading instance with PRESCALE=1, checked with immediate assertions.
module tb_countdown_timer_ctrl;

    logic       clk;
    logic       rst;

    logic       a_start, a_pause, a_abort;
    logic [3:0] a_load;
    logic [3:0] a_count;
    logic       a_tick, a_busy, a_done;

    logic       b_start, b_pause, b_abort;
    logic [3:0] b_load;
    logic [3:0] b_count;
    logic       b_tick, b_busy, b_done;

    int checks = 0;
    int errors = 0;

    countdown_timer_ctrl #(.WIDTH(4), .PRESCALE(2), .AUTO_RELOAD(1'b0)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .load_val(a_load),
        .pause(a_pause), .abort(a_abort), .count(a_count),
        .tick(a_tick), .busy(a_busy), .done(a_done)
    );

    countdown_timer_ctrl #(.WIDTH(4), .PRESCALE(1), .AUTO_RELOAD(1'b1)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .load_val(b_load),
        .pause(b_pause), .abort(b_abort), .count(b_count),
        .tick(b_tick), .busy(b_busy), .done(b_done)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one active edge, then settle before driving or sampling
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] c, input logic t,
                         input logic b, input logic d);
        chk({tag, ".count"}, {4'd0, a_count}, {4'd0, c});
        chk({tag, ".tick"},  {7'd0, a_tick},  {7'd0, t});
        chk({tag, ".busy"},  {7'd0, a_busy},  {7'd0, b});
        chk({tag, ".done"},  {7'd0, a_done},  {7'd0, d});
    endtask

    logic [3:0] exp_cnt [0:9];
    logic       exp_tck [0:9];
    logic       exp_bsy [0:9];
    logic       exp_dn  [0:9];

    initial begin
        rst = 1'b1;
        a_start = 1'b0; a_pause = 1'b0; a_abort = 1'b0; a_load = 4'd0;
        b_start = 1'b0; b_pause = 1'b0; b_abort = 1'b0; b_load = 4'd0;
        cyc();
        cyc();
        rst = 1'b0;
        chk_a("reset_a", 4'd0, 1'b0, 1'b0, 1'b0);
        chk("reset_b.count", {4'd0, b_count}, 8'd0);
        chk("reset_b.busy",  {7'd0, b_busy},  8'd0);

        // load 3 with two clocks per count: 3,3,2,2,1,1,0 then done for one cycle
        exp_cnt = '{4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
        exp_tck = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_bsy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_dn  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        a_start = 1'b1; a_load = 4'd3;
        chk("s1_pre.tick", {7'd0, a_tick}, 8'd0);
        for (int k = 0; k < 8; k++) begin
            cyc();
            a_start = 1'b0;
            chk_a($sformatf("s1_e%0d", k), exp_cnt[k], exp_tck[k], exp_bsy[k], exp_dn[k]);
        end

        // zero load goes straight to a single done pulse without busy
        a_start = 1'b1; a_load = 4'd0;
        cyc();
        a_start = 1'b0;
        chk_a("s2_e0", 4'd0, 1'b0, 1'b0, 1'b1);
        cyc();
        chk_a("s2_e1", 4'd0, 1'b0, 1'b0, 1'b0);

        // load 5, pause for 7 cycles once count is 4
        a_start = 1'b1; a_load = 4'd5;
        cyc();
        a_start = 1'b0;
        chk_a("s3_e0", 4'd5, 1'b0, 1'b1, 1'b0);
        cyc();
        cyc();
        chk("s3_e2.count", {4'd0, a_count}, 8'd4);
        a_pause = 1'b1;
        chk("s3_p.tick", {7'd0, a_tick}, 8'd0);
        for (int k = 0; k < 7; k++) begin
            cyc();
            chk_a($sformatf("s3_pause%0d", k), 4'd4, 1'b0, 1'b1, 1'b0);
        end
        a_pause = 1'b0;
        exp_cnt = '{4'd4, 4'd4, 4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0};
        exp_dn  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk($sformatf("s3_r%0d.count", k), {4'd0, a_count}, {4'd0, exp_cnt[k]});
            chk($sformatf("s3_r%0d.done", k),  {7'd0, a_done},  {7'd0, exp_dn[k]});
        end

        // load 9, abort together with start at count 6
        a_start = 1'b1; a_load = 4'd9;
        cyc();
        a_start = 1'b0;
        for (int k = 0; k < 6; k++) cyc();
        chk_a("s4_e6", 4'd6, 1'b0, 1'b1, 1'b0);
        a_abort = 1'b1; a_start = 1'b1; a_load = 4'd3;
        cyc();
        a_abort = 1'b0; a_start = 1'b0;
        chk_a("s4_abort", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        chk_a("s4_after", 4'd0, 1'b0, 1'b0, 1'b0);

        // reset mid-count at 7 with the prescaler about to tick
        a_start = 1'b1; a_load = 4'd9;
        cyc();
        a_start = 1'b0;
        for (int k = 0; k < 5; k++) cyc();
        chk_a("s6_pre", 4'd7, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_a("s6_rst", 4'd0, 1'b0, 1'b0, 1'b0);
        a_start = 1'b1; a_load = 4'd4;
        exp_cnt = '{4'd4, 4'd4, 4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0};
        exp_tck = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_bsy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_dn  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 10; k++) begin
            cyc();
            a_start = 1'b0;
            chk_a($sformatf("s6_e%0d", k), exp_cnt[k], exp_tck[k], exp_bsy[k], exp_dn[k]);
        end

        // auto-reload, one clock per count: 2,1,0 repeating, done every third cycle
        b_start = 1'b1; b_load = 4'd2;
        exp_cnt = '{4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd0};
        exp_dn  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_tck = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 8; k++) begin
            cyc();
            b_start = 1'b0;
            chk($sformatf("s5_e%0d.count", k), {4'd0, b_count}, {4'd0, exp_cnt[k]});
            chk($sformatf("s5_e%0d.done", k),  {7'd0, b_done},  {7'd0, exp_dn[k]});
            chk($sformatf("s5_e%0d.tick", k),  {7'd0, b_tick},  {7'd0, exp_tck[k]});
        end
        b_abort = 1'b1;
        cyc();
        b_abort = 1'b0;
        chk("s5_abort.count", {4'd0, b_count}, 8'd0);
        chk("s5_abort.busy",  {7'd0, b_busy},  8'd0);
        chk("s5_abort.done",  {7'd0, b_done},  8'd0);
        cyc();
        cyc();
        chk("s5_idle.count", {4'd0, b_count}, 8'd0);
        chk("s5_idle.done",  {7'd0, b_done},  8'd0);
        chk("s5_idle.busy",  {7'd0, b_busy},  8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
